// File: rtl/neander_fetch.sv
// Neander-style fetch unit: loads a program, then fetches IR and operand data (RDM) through a shared memory.
// Operand is presented 6 edges after start/handshake; VALID holds until op_ready, then store/pc update apply.
module neander_fetch #(
    parameter int ADDR_W = 4,
    parameter int OP_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_en,
    input  logic [ADDR_W-1:0]      ld_addr,
    input  logic [OP_W+ADDR_W-1:0] ld_data,
    input  logic                   start,
    input  logic                   op_ready,
    input  logic                   st_en,
    input  logic [OP_W+ADDR_W-1:0] st_data,
    input  logic                   jmp,
    output logic                   op_valid,
    output logic [OP_W-1:0]        opcode,
    output logic [ADDR_W-1:0]      operand,
    output logic [OP_W+ADDR_W-1:0] data,
    output logic [ADDR_W-1:0]      pc,
    output logic                   halted,
    output logic                   busy,
    output logic [2:0]             state
);
    localparam int W     = OP_W + ADDR_W;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_F_ADDR  = 3'd1,
        S_F_READ  = 3'd2,
        S_F_IR    = 3'd3,
        S_D_READ  = 3'd4,
        S_D_LATCH = 3'd5,
        S_VALID   = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        mem [DEPTH];
    logic [ADDR_W-1:0]   pc_q, rem_q;
    logic [W-1:0]        ir_q, rdm_q, mem_q;
    logic                hs;
    logic                ir_halt;

    assign hs      = (state_q == S_VALID) && op_ready;
    assign ir_halt = &ir_q[W-1:ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start && !ld_en) state_d = S_F_ADDR;
            S_F_ADDR:  state_d = S_F_READ;
            S_F_READ:  state_d = S_F_IR;
            S_F_IR:    state_d = S_D_READ;
            S_D_READ:  state_d = S_D_LATCH;
            S_D_LATCH: state_d = S_VALID;
            S_VALID:   if (op_ready) state_d = ir_halt ? S_HALT : S_F_ADDR;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= '0;
            rem_q <= '0;
            ir_q  <= '0;
            rdm_q <= '0;
            mem_q <= '0;
        end else begin
            case (state_q)
                S_F_ADDR:  rem_q <= pc_q;
                S_F_READ:  mem_q <= mem[rem_q];
                S_F_IR: begin
                    ir_q  <= mem_q;
                    rem_q <= mem_q[ADDR_W-1:0];
                end
                S_D_READ:  mem_q <= mem[rem_q];
                S_D_LATCH: rdm_q <= mem_q;
                S_VALID: begin
                    if (op_ready) pc_q <= jmp ? ir_q[ADDR_W-1:0] : pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
                default: ;
            endcase
        end
    end

    // Memory is never reset; rst only suppresses writes in its own cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_IDLE && ld_en) mem[ld_addr] <= ld_data;
            else if (hs && st_en)            mem[ir_q[ADDR_W-1:0]] <= st_data;
        end
    end

    assign op_valid = (state_q == S_VALID);
    assign halted   = (state_q == S_HALT);
    assign busy     = (state_q != S_IDLE) && (state_q != S_HALT);
    assign state    = state_q;
    assign opcode   = ir_q[W-1:ADDR_W];
    assign operand  = ir_q[ADDR_W-1:0];
    assign data     = rdm_q;
    assign pc       = pc_q;
endmodule

// File: tb/tb_neander_fetch.sv
// Bench for neander_fetch: directed program plus randomized traffic against a transaction-level model.
module tb_neander_fetch;
    logic       clk, rst, ld_en, start, op_ready, st_en, jmp;
    logic [3:0] ld_addr;
    logic [7:0] ld_data, st_data;
    logic       op_valid, halted, busy;
    logic [3:0] opcode, operand, pc;
    logic [7:0] data;
    logic [2:0] state;

    neander_fetch #(.ADDR_W(4), .OP_W(4)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .op_ready(op_ready), .st_en(st_en), .st_data(st_data), .jmp(jmp),
        .op_valid(op_valid), .opcode(opcode), .operand(operand), .data(data),
        .pc(pc), .halted(halted), .busy(busy), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one fetch = read mem[pc] then mem[operand], visible after 6 edges.
    localparam int M_IDLE = 0, M_FETCH = 1, M_VALID = 2, M_HALT = 3;
    int         m_mode = M_IDLE;
    int         m_cnt  = 0;
    logic [3:0] m_pc   = 4'd0;
    logic [7:0] m_ir   = 8'd0;
    logic [7:0] m_data = 8'd0;
    logic [7:0] m_mem [16];

    task automatic begin_fetch();
        m_ir   = m_mem[m_pc];
        m_data = m_mem[m_ir[3:0]];
        m_cnt  = 5;
        m_mode = M_FETCH;
    endtask

    function automatic logic [2:0] exp_state();
        case (m_mode)
            M_IDLE:  return 3'd0;
            M_FETCH: return 3'(6 - m_cnt);
            M_VALID: return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode = M_IDLE;
            m_pc   = 4'd0;
            m_cnt  = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (ld_en) m_mem[ld_addr] = ld_data;
                    else if (start) begin_fetch();
                end
                M_FETCH: begin
                    m_cnt--;
                    if (m_cnt == 0) m_mode = M_VALID;
                end
                M_VALID: begin
                    if (op_ready) begin
                        if (st_en) m_mem[m_ir[3:0]] = st_data;
                        m_pc = jmp ? m_ir[3:0] : 4'((m_pc + 1) % 16);
                        if (m_ir[7:4] == 4'hF) m_mode = M_HALT;
                        else begin_fetch();
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", state, exp_state());
            chk("pc", pc, m_pc);
            chk("op_valid", op_valid, m_mode == M_VALID);
            chk("halted", halted, m_mode == M_HALT);
            chk("busy", busy, m_mode == M_FETCH || m_mode == M_VALID);
            if (m_mode == M_VALID) begin
                chk("opcode", opcode, m_ir[7:4]);
                chk("operand", operand, m_ir[3:0]);
                chk("data", data, m_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!op_valid && n < 20) begin
            step();
            n++;
        end
        chk(nm, op_valid, 1'b1);
    endtask

    task automatic handshake(input logic s, input logic [7:0] sd, input logic j);
        op_ready = 1'b1; st_en = s; st_data = sd; jmp = j;
        step();
        op_ready = 1'b0; st_en = 1'b0; st_data = 8'h00; jmp = 1'b0;
    endtask

    logic [7:0] prog [16];

    initial begin
        int n;
        rst = 1'b1; ld_en = 0; ld_addr = 0; ld_data = 0; start = 0;
        op_ready = 0; st_en = 0; st_data = 0; jmp = 0;
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = 8'h25; prog[1] = 8'h19; prog[2] = 8'h29; prog[3] = 8'h1E;
        prog[5] = 8'hA7; prog[14] = 8'h6F; prog[15] = 8'hF0;

        step(); step();
        chk_en = 1;
        chk("rst_state", state, 3'd0);
        chk("rst_pc", pc, 4'd0);
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            ld_en = 1'b1; ld_addr = 4'(i); ld_data = prog[i];
            step();
        end
        ld_en = 1'b0;

        // First fetch: latency counted including the edge that samples start.
        start = 1'b1; step(); start = 1'b0;
        n = 1;
        while (!op_valid && n < 20) begin
            step();
            n++;
        end
        chk("first_latency", n, 6);
        chk("i0_opcode", opcode, 4'h2);
        chk("i0_operand", operand, 4'h5);
        chk("i0_data", data, 8'hA7);
        chk("i0_pc", pc, 4'h0);

        // Hold: st_en/jmp without op_ready must have no effect.
        st_en = 1'b1; jmp = 1'b1; st_data = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_valid", op_valid, 1'b1);
            chk("hold_opcode", opcode, 4'h2);
            chk("hold_data", data, 8'hA7);
        end
        st_en = 1'b0; jmp = 1'b0;
        handshake(1'b0, 8'h00, 1'b0);
        chk("hs1_pc", pc, 4'h1);
        chk("hs1_op_valid", op_valid, 1'b0);

        wait_valid("i1_valid");
        chk("i1_operand", operand, 4'h9);
        handshake(1'b1, 8'h3C, 1'b0);
        chk("hs2_pc", pc, 4'h2);

        wait_valid("i2_valid");
        chk("i2_stored_data", data, 8'h3C);
        handshake(1'b0, 8'h00, 1'b0);

        wait_valid("i3_valid");
        chk("i3_operand", operand, 4'hE);
        handshake(1'b0, 8'h00, 1'b1);
        chk("jmp_pc", pc, 4'hE);

        wait_valid("i14_valid");
        chk("i14_opcode", opcode, 4'h6);
        chk("i14_data", data, 8'hF0);
        handshake(1'b0, 8'h00, 1'b0);
        chk("pc15", pc, 4'hF);

        wait_valid("i15_valid");
        chk("i15_opcode", opcode, 4'hF);
        handshake(1'b0, 8'h00, 1'b0);
        chk("halt_halted", halted, 1'b1);
        chk("halt_pc_wrap", pc, 4'h0);
        chk("halt_op_valid", op_valid, 1'b0);

        start = 1'b1; ld_en = 1'b1; ld_addr = 4'h0; ld_data = 8'hFF;
        step(); step(); step();
        chk("halt_absorb", state, 3'd7);
        start = 1'b0; ld_en = 1'b0;

        rst = 1'b1; step(); rst = 1'b0;
        chk("post_halt_state", state, 3'd0);
        chk("post_halt_pc", pc, 4'h0);
        start = 1'b1; step(); start = 1'b0;
        wait_valid("intact_valid");
        chk("intact_opcode", opcode, 4'h2);
        chk("intact_data", data, 8'hA7);

        handshake(1'b0, 8'h00, 1'b0);
        n = 0;
        while (state != 3'd4 && n < 10) begin
            step();
            n++;
        end
        chk("reach_d_read", state, 3'd4);
        rst = 1'b1; step(); rst = 1'b0;
        chk("abort_state", state, 3'd0);

        start = 1'b1; ld_en = 1'b1; ld_addr = 4'hA; ld_data = 8'h5A;
        step();
        start = 1'b0; ld_en = 1'b0;
        chk("ld_over_start", state, 3'd0);

        // Randomized traffic; model tracks every store, load and reset.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 63) == 0);
            ld_en    = ($urandom_range(0, 3) == 0);
            ld_addr  = 4'($urandom_range(0, 15));
            ld_data  = 8'($urandom_range(0, 255));
            start    = ($urandom_range(0, 1) == 0);
            op_ready = ($urandom_range(0, 2) == 0);
            st_en    = ($urandom_range(0, 2) == 0);
            st_data  = 8'($urandom_range(0, 255));
            jmp      = ($urandom_range(0, 3) == 0);
            step();
        end
        rst = 1'b0; ld_en = 0; start = 0; op_ready = 0; st_en = 0; jmp = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
